// File: rtl/decoder_pkg.sv
// decoder_pkg: shared definitions for the decoder_scan block.
//   mode_e -- operating mode encoding (direct decode vs. auto-scan).
package decoder_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: per-step hold counter for the auto-scan sequencer.
//   clk, rst_n -- clock, async active-low reset
//   run        -- counting enabled; when low the count is cleared
//   dwell      -- extra cycles each step is held (sampled every cycle)
//   step       -- combinational pulse: current step has expired
//   cnt        -- current count
module dwell_counter #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               step,
    output logic [DWELL_W-1:0] cnt
);

    // >= rather than == so that lowering dwell below the running count
    // still ends the step on the very next edge.
    assign step = run && (cnt >= dwell);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || step) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: N-to-2**N one-hot decoder with a direct-select mode and an
// auto-scan mode that walks every output, holding each for dwell+1 cycles.
//   clk, rst_n -- clock, async active-low reset
//   en         -- block enable; low forces all outputs inactive
//   mode       -- 0 direct decode of sel, 1 auto-scan
//   sel        -- index to decode in direct mode, qualified by sel_valid
//   dwell      -- extra hold cycles per scan step
//   out        -- one-hot lines (inverted when ACTIVE_LOW)
//   out_valid  -- out carries a decoded index
//   idx        -- registered index being decoded
//   wrap       -- one-cycle pulse when the scan wraps back to index 0
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int N          = 3,
    parameter int DWELL_W    = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [N-1:0]        sel,
    input  logic                sel_valid,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [(2**N)-1:0]   out,
    output logic                out_valid,
    output logic [N-1:0]        idx,
    output logic                wrap
);

    localparam int LINES = 2**N;

    logic               active;
    logic               scanning;
    logic               step;
    logic               run;
    logic [DWELL_W-1:0] cnt;

    // Counter only advances while a scan is already in progress; any other
    // condition (disable, direct mode, scan entry) clears it.
    assign run = en && (mode == MODE_SCAN) && scanning;

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .dwell (dwell),
        .step  (step),
        .cnt   (cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            active   <= 1'b0;
            scanning <= 1'b0;
            wrap     <= 1'b0;
        end else if (!en) begin
            active   <= 1'b0;
            scanning <= 1'b0;
            wrap     <= 1'b0;
        end else if (mode == MODE_SCAN) begin
            active <= 1'b1;
            if (!scanning) begin
                idx      <= '0;
                scanning <= 1'b1;
                wrap     <= 1'b0;
            end else if (step) begin
                idx  <= idx + 1'b1;
                wrap <= &idx;
            end else begin
                wrap <= 1'b0;
            end
        end else begin
            scanning <= 1'b0;
            wrap     <= 1'b0;
            if (sel_valid) begin
                idx    <= sel;
                active <= 1'b1;
            end
        end
    end

    // Decoded from registered state so reset takes effect on out immediately.
    logic [LINES-1:0] dec;
    always_comb begin
        dec = '0;
        if (active) dec[idx] = 1'b1;
    end

    assign out       = (ACTIVE_LOW != 0) ? ~dec : dec;
    assign out_valid = active;

endmodule

// File: tb/tb_decoder_scan.sv
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] sel;
    logic       sel_valid;
    logic [3:0] dwell;

    logic [7:0] out, out_al;
    logic       out_valid, out_valid_al;
    logic [2:0] idx, idx_al;
    logic       wrap, wrap_al;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder_scan #(.N(3), .DWELL_W(4), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .dwell(dwell), .out(out),
        .out_valid(out_valid), .idx(idx), .wrap(wrap)
    );

    decoder_scan #(.N(3), .DWELL_W(4), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .dwell(dwell), .out(out_al),
        .out_valid(out_valid_al), .idx(idx_al), .wrap(wrap_al)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs are then changed and outputs sampled
    // 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] e_idx,
                             input logic e_act, input logic e_wrap);
        logic [7:0] e_out;
        e_out = e_act ? (8'h01 << e_idx) : 8'h00;
        chk({tag, ".idx"},       idx,       e_idx);
        chk({tag, ".out"},       out,       e_out);
        chk({tag, ".out_valid"}, out_valid, e_act);
        chk({tag, ".wrap"},      wrap,      e_wrap);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; sel_valid = 1'b0; dwell = '0;
        #3;
        chk_state("reset", 3'd0, 1'b0, 1'b0);
        chk("reset.out_al", out_al, 8'hFF);
        tick();
        rst_n = 1'b1;

        // Direct sweep
        en = 1'b1; mode = 1'b0; sel_valid = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick();
            chk_state($sformatf("direct%0d", s), 3'(s), 1'b1, 1'b0);
            if (s == 2) chk("direct2.out_al", out_al, 8'hFB);
        end
        sel_valid = 1'b0; sel = 3'd5;
        tick();
        chk_state("direct_hold", 3'd7, 1'b1, 1'b0);

        // Disable clears out, idx holds
        en = 1'b0;
        tick();
        chk_state("disable", 3'd7, 1'b0, 1'b0);

        // Scan with dwell=0
        en = 1'b1; mode = 1'b1; dwell = 4'd0;
        tick();
        chk_state("scan0_entry", 3'd0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_state($sformatf("scan0_%0d", i), 3'(i), 1'b1, 1'b0);
        end
        tick();
        chk_state("scan0_wrap", 3'd0, 1'b1, 1'b1);
        tick();
        chk_state("scan0_after_wrap", 3'd1, 1'b1, 1'b0);

        // Scan with dwell=2, then lower dwell mid-step
        en = 1'b0;
        tick();
        en = 1'b1; dwell = 4'd2;
        tick();
        chk_state("scan2_entry", 3'd0, 1'b1, 1'b0);
        tick();
        chk_state("scan2_hold1", 3'd0, 1'b1, 1'b0);
        tick();
        chk_state("scan2_hold2", 3'd0, 1'b1, 1'b0);
        tick();
        chk_state("scan2_step1", 3'd1, 1'b1, 1'b0);
        tick();
        chk_state("scan2_idx1_hold", 3'd1, 1'b1, 1'b0);
        dwell = 4'd0;
        tick();
        chk_state("scan_dwell_lowered", 3'd2, 1'b1, 1'b0);

        // sel ignored during scan
        sel = 3'd6; sel_valid = 1'b1;
        tick();
        chk_state("scan_sel_ignored", 3'd3, 1'b1, 1'b0);
        sel_valid = 1'b0;
        tick();
        tick();
        chk_state("scan_at5", 3'd5, 1'b1, 1'b0);

        // en=0 at idx 5, then restart
        en = 1'b0;
        tick();
        chk_state("mid_disable", 3'd5, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        chk_state("restart", 3'd0, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk_state("scan_at3", 3'd3, 1'b1, 1'b0);

        // Async reset at idx 3
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("mid_reset", 3'd0, 1'b0, 1'b0);
        chk("mid_reset.out_al", out_al, 8'hFF);
        tick();
        rst_n = 1'b1;
        tick();
        chk_state("post_reset_entry", 3'd0, 1'b1, 1'b0);
        tick();
        chk_state("post_reset_step", 3'd1, 1'b1, 1'b0);

        // Scan -> direct with sel_valid=0: idx holds, still active
        mode = 1'b0; sel_valid = 1'b0;
        tick();
        chk_state("to_direct_hold", 3'd1, 1'b1, 1'b0);
        sel = 3'd4; sel_valid = 1'b1;
        tick();
        chk_state("to_direct_sel", 3'd4, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter N, default 3, select width; output width is 2**N.
REQ-002 Parameter DWELL_W, default 4, width of the dwell-count input.
REQ-003 Parameter ACTIVE_LOW, default 0; when 1, every output line is inverted.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  block enable.
REQ-007 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 sel  input  N  select index, direct mode.
REQ-009 sel_valid  input  1  qualifies sel.
REQ-010 dwell  input  DWELL_W  extra cycles each scan step is held.
REQ-011 out  output  2**N  one-hot decoded lines.
REQ-012 out_valid  output  1  out carries a decoded index.
REQ-013 idx  output  N  registered index currently decoded.
REQ-014 wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-015 Internal registers: idx, active flag, dwell counter cnt (DWELL_W bits), scanning flag.
REQ-016 out shall be decoded from registered idx and active: active=1 gives a single bit idx high; active=0 gives all bits low; ACTIVE_LOW inverts the result.
REQ-017 out_valid shall equal active.
REQ-018 Direct mode, en=1, sel_valid=1: idx<=sel, active<=1; out is updated one cycle after sel is sampled.
REQ-019 Direct mode, en=1, sel_valid=0: idx and out shall hold; active shall hold.
REQ-020 Scan entry (en=1, mode=1, scanning=0): idx<=0, cnt<=0, active<=1, scanning<=1, wrap<=0.
REQ-021 Scan step (scanning=1): if cnt==dwell, then cnt<=0 and idx<=idx+1 modulo 2**N; otherwise cnt<=cnt+1. Each index is therefore held for dwell+1 cycles.
REQ-022 wrap shall be 1 for exactly the cycle after idx advances from 2**N-1 to 0; otherwise 0.
REQ-023 sel and sel_valid shall be ignored while mode=1.
REQ-024 The dwell value shall be sampled at every comparison. If cnt>dwell after dwell is lowered, the step fires on the next edge.
REQ-025 mode 1->0 with en=1: scanning<=0 and cnt<=0; direct behaviour applies from the same edge; idx holds unless sel_valid=1.
REQ-026 en=0: active<=0, scanning<=0, cnt<=0, wrap<=0; idx holds; out goes all-inactive on the next edge.
REQ-027 en 0->1 with mode=1 shall restart the scan at idx 0 (scan entry).
REQ-028 dwell=0 shall advance idx every cycle.

Reset
REQ-029 While rst_n=0: idx=0, cnt=0, active=0, scanning=0, wrap=0, out_valid=0, out all-inactive (all 0, or all 1 when ACTIVE_LOW). Effect is immediate, independent of clk.
REQ-030 Deassertion of reset: the first edge with rst_n=1 shall behave as a normal cycle.
REQ-031 Reset mid-scan: the next scan entry restarts from idx 0.

Structure
REQ-032 Package decoder_pkg shall hold MODE_DIRECT=0 and MODE_SCAN=1.
REQ-033 Sub-module dwell_counter shall implement cnt, compare and step pulse, with DWELL_W as its parameter.
REQ-034 The target implementation size is 120-400 lines of RTL.

Verification (N=3, ACTIVE_LOW=0 unless stated)
REQ-035 Reset: hold rst_n=0 -> out=8'h00, out_valid=0, idx=0, wrap=0.
REQ-036 Direct sweep: en=1, mode=0, sel=0..7 each with sel_valid=1 -> one cycle later out=1<<sel, out_valid=1; a sel_valid=0 cycle holds out.
REQ-037 Scan with dwell=0: en=1, mode=1 -> idx sequence 0,1,...,7,0; wrap=1 on the single cycle idx returns to 0.
REQ-038 Scan with dwell=2: each idx is held 3 cycles; lowering dwell to 0 mid-step advances on the next edge.
REQ-039 Mid-scan events: en=0 at idx=5 -> out=8'h00 next cycle; en=1 restarts at idx=0. rst_n pulse at idx=3 -> immediate reset values.
REQ-040 ACTIVE_LOW=1, direct sel=2 -> out=8'hFB; under reset -> out=8'hFF.
